// File: rtl/apb_pkg.sv
// Shared APB types and sizes for the 16x8 RAM master/slave pair.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase wait-state counter for the APB master; flags when the wait budget is used up.
module apb_mst_wdog
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_ram_master.sv
// APB master bridge: one valid/ready command -> one APB SETUP/ACCESS transfer -> one response.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_ram_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_ram_master: TIMEOUT_CYC must be within 2..255");
  end

  apb_state_t        state, state_n;
  logic              psel_n, penable_n, pwrite_n, req_ready_n;
  logic              rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;
  logic              expire;

`ifdef APB_TIMEOUT_EN
  apb_mst_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (state == SETUP),
    .inc     (state == ACCESS && !pready),
    .expired (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    psel_n        = psel;
    penable_n     = penable;
    pwrite_n      = pwrite;
    paddr_n       = paddr;
    pwdata_n      = pwdata;
    req_ready_n   = req_ready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        psel_n      = 1'b0;
        penable_n   = 1'b0;
        if (req_valid && req_ready) begin
          pwrite_n    = req_write;
          paddr_n     = req_addr;
          pwdata_n    = req_wdata;
          req_ready_n = 1'b0;
          psel_n      = 1'b1;
          state_n     = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
      end
      ACCESS: begin
        // pready wins over an expiry landing on the same edge
        if (pready) begin
          rsp_rdata_n   = (pwrite || pslverr) ? '0 : prdata;
          rsp_err_n     = pslverr;
          rsp_timeout_n = 1'b0;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = RESP;
        end else if (expire) begin
          rsp_rdata_n   = '0;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      psel        <= psel_n;
      penable     <= penable_n;
      pwrite      <= pwrite_n;
      paddr       <= paddr_n;
      pwdata      <= pwdata_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

endmodule

// File: doc/apb_ram_master.md
Name: apb_ram_master

Overview:
- APB master bridge directly upstream of the 16x8 APB RAM slave.
- Accepts single read/write commands on a valid/ready request channel and runs one APB transfer per command: SETUP phase, then ACCESS phase held until pready.
- Returns read data and error status on a valid/ready response channel.
- Used by test sequencers and CPU-side logic to reach the RAM without hand-driving APB phases.

Parameters:
- ADDR_W, 32, APB address width (paddr, req_addr).
- DATA_W, 8, APB data width (pwdata, prdata, req_wdata, rsp_rdata).
- TIMEOUT_CYC, 16, maximum ACCESS cycles before forced termination (used only with APB_TIMEOUT_EN); legal range 2..255.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored transfers.
- rsp_err  out  1  pslverr (or timeout) seen on completion.
- rsp_timeout  out  1  transfer was terminated by timeout; constant 0 without APB_TIMEOUT_EN.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready (may be combinational in slave).
- pslverr  in  1  APB slave error, valid when psel && penable && pready.

Behaviour:
- All outputs are registered. Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; state=IDLE.
- IDLE:
  - req_ready=1, psel=0, penable=0.
  - On accept, latch req_write/req_addr/req_wdata into pwrite/paddr/pwdata, drop req_ready, go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; go to ACCESS.
- ACCESS:
  - psel=1, penable=1; hold all APB outputs stable while pready=0 (wait states are unbounded without the macro).
  - On pready=1: rsp_rdata = pwrite ? 0 : (pslverr ? 0 : prdata); rsp_err = pslverr; rsp_timeout = 0.
  - In the same edge drop psel and penable, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1 and fields held stable until rsp_ready=1.
  - Then clear rsp_valid, set req_ready=1, go to IDLE.
  - A stalled rsp_ready back-pressures the request channel; no new command is accepted while a response is pending.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2 → with zero wait states, rsp_valid at N+3. Minimum 4 cycles per command with rsp_ready tied 1.
- After a transfer, paddr/pwdata/pwrite keep their last values; only psel/penable return to 0.
- pready or pslverr outside ACCESS is ignored.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Addresses above 15 are not filtered by the master; they are passed through, and the slave's pslverr is reported in rsp_err.
- Reset mid-transfer (any state): immediate return to reset values. The in-flight command is dropped and no response is generated.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro:
  - An ACCESS cycle counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC-1 with pready still 0, the transfer is forced to complete on that edge: psel=0, penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - pready=1 in that same cycle wins: normal completion, no timeout.
- Without the macro: no counter is built, ACCESS waits indefinitely, and rsp_timeout is tied 0.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP} (2-bit);
  - localparams APB_ADDR_W=32, APB_DATA_W=8, RAM_DEPTH=16;
  - packed typedef apb_req_t {write, addr, wdata};
  - packed typedef apb_rsp_t {rdata, err, timeout}.
- One natural sub-module: apb_mst_wdog (counter plus expiry flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write addr 0x3, data 0xA5, slave pready immediate → SETUP (psel=1, penable=0) for 1 cycle, ACCESS for 1 cycle, rsp_valid=1 three cycles after accept, rsp_err=0, rsp_rdata=0x00.
- Read addr 0x3 after that write → rsp_rdata=0xA5, rsp_err=0; paddr=0x3 stable through SETUP and ACCESS.
- Read addr 0x20 → slave asserts pslverr with pready; rsp_err=1, rsp_rdata=0x00, master returns to IDLE.
- Slave pready held low 5 ACCESS cycles, then read of 0x7 containing 0x3C → psel/penable/paddr stable for all 5 wait cycles; rsp_rdata=0x3C.
- rsp_ready held low 10 cycles with req_valid=1 pending → req_ready stays 0 and no second SETUP occurs; first response held stable; second command starts the cycle after rsp_ready=1.
- Assert presetn=0 during ACCESS → psel/penable/rsp_valid are 0 immediately; after release no response appears and req_ready=1. With APB_TIMEOUT_EN and TIMEOUT_CYC=16, pready held low → forced completion after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1.
